stream_mod_router: RTL
======================

Name: stream_mod_router

Overview:
- Generalised successor to the two-way MultiStream divisibility splitter.
- Accepts one Pico input stream of W-bit words and classifies each word by the residue of its low KEY_BITS bits modulo a divisor held in a PicoBus register.
- Routes each word to one of NUM_OUT output streams. Each output has its own FIFO and a per-output word counter readable over the bus.
- Sits between the host-facing input stream and the user output streams in the MultiStream firmware.

Parameters:
- W, 128, stream data width in bits.
- NUM_OUT, 4, number of output streams (2..8).
- FIFO_DEPTH, 16, entries per output FIFO (power of 2, at least 4).
- KEY_BITS, 4, number of low data bits used as the classification key (1..8).
- BASE_ADDR, 32'h0, PicoBus base address of the register block.

Ports:
- clk  in  1  single clock, used for streams and bus.
- rst_n  in  1  asynchronous, active-low reset.
- s_in_valid  in  1  input word valid.
- s_in_rdy  out  1  input ready; a word transfers when s_in_valid and s_in_rdy are both high.
- s_in_data  in  W  input word.
- s_out_valid  out  NUM_OUT  per-output valid.
- s_out_rdy  in  NUM_OUT  per-output ready.
- s_out_data  out  NUM_OUT*W  output k occupies bits [k*W +: W].
- bus_addr  in  32  PicoBus address.
- bus_wr  in  1  one-cycle write strobe.
- bus_rd  in  1  one-cycle read strobe.
- bus_din  in  32  write data.
- bus_dout  out  32  read data.
- bus_dout_valid  out  1  read data valid.

Behaviour:
- Reset (rst_n low, asynchronous):
  - s_in_rdy=0, s_out_valid=0, s_out_data=0, bus_dout=0, bus_dout_valid=0.
  - FIFOs emptied, counters cleared, divisor=2, mode=0, err=0.
  - s_in_rdy rises on the first clk edge after rst_n deasserts.
  - Reset mid-stream discards all in-flight and buffered words.
- Registers (byte offsets from BASE_ADDR):
  - +0x00 divisor, RW, 8 bits.
  - +0x04 mode, RW, bit 0.
  - +0x08 control, W. Writing bit 0 = 1 clears all counters; writing bit 1 = 1 clears err.
  - +0x0C status, R. Bit 0 = err; bits [8+k] = FIFO k empty.
  - +0x10+4k count_k, R, 32 bits, wraps at 2^32.
- Bus reads:
  - bus_dout and bus_dout_valid are driven one cycle after bus_rd, for exactly one cycle.
  - Unmapped addresses read 0; writes to unmapped addresses are ignored.
- Classification: key = s_in_data[KEY_BITS-1:0], r = key mod divisor.
  - Mode 0 (binary): destination = 1 if r==0, else 0. Outputs 2..NUM_OUT-1 stay idle.
  - Mode 1 (residue): destination = r if r < NUM_OUT, else NUM_OUT-1.
  - Divisor 0: every word goes to output 0 and err is set (sticky).
  - Divisor is sampled when the word is accepted. A bus write in the same cycle takes effect for the next accepted word.
- Pipeline:
  - S0: input register, loaded on transfer.
  - S1: residue compute and destination decode.
  - FIFO write on the following edge.
  - A word accepted at edge t is presented on s_out_valid[dest] at edge t+3 if that FIFO was empty and its output was idle.
- Credits and stalls:
  - Each output keeps a credit count = FIFO occupancy + in-flight words destined for it.
  - S1 advances only if credit[dest] < FIFO_DEPTH; otherwise S0 and S1 hold.
  - s_in_rdy = !(S0 full and stalled).
  - Head-of-line blocking on a full destination is intended. Words are never dropped or duplicated.
  - Order is preserved within each output; no ordering is guaranteed across outputs.
- Outputs: standard valid/ready. s_out_data is stable while valid is high and ready is low. FIFO k pops when s_out_valid[k] and s_out_rdy[k] are both high.
- Counters:
  - count_k increments when a word is written into FIFO k.
  - If a clear and an increment occur in the same cycle, the counter ends at 1.
- A FIFO push and pop in the same cycle on a full FIFO is allowed; occupancy is unchanged.

Test Plan:
- Mode 0, divisor 2, stream words 0..255, all outputs ready -> out1 carries 0,2,..,254 (128 words); out0 carries 1,3,..,255; count_0=count_1=128; err=0.
- Mode 1, divisor 3, NUM_OUT=4, words 0..15 (key 4 bits) -> out0 gets {0,3,6,9,12,15}, out1 gets {1,4,7,10,13}, out2 gets {2,5,8,11,14}, out3 gets nothing.
- s_out_rdy[1]=0, mode 0, divisor 2, stream all-even keys -> exactly FIFO_DEPTH words buffered, then s_in_rdy stays low. Raising s_out_rdy[1] drains all words in order with none lost.
- Divisor written to 0, then 8 words -> all 8 words appear on out0; status bit 0 = 1. Control write 0x2 clears err.
- Single word accepted into empty pipeline -> s_out_valid[dest] rises exactly 3 clk after acceptance. Bus read of count issued at cycle c -> bus_dout_valid high at c+1 only.
- rst_n pulsed low with 5 words in flight -> all s_out_valid drop asynchronously; counters read 0; divisor reads 2; no stale word appears after reset.

Source files
------------

// File: rtl/stream_mod_router.sv
// Routes each input word to one of NUM_OUT buffered output streams by the residue of its
// low key bits modulo a bus-programmable divisor; per-output word counters on PicoBus.
module stream_mod_router #(
    parameter int          W          = 128,
    parameter int          NUM_OUT    = 4,
    parameter int          FIFO_DEPTH = 16,
    parameter int          KEY_BITS   = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   s_in_valid,
    output logic                   s_in_rdy,
    input  logic [W-1:0]           s_in_data,
    output logic [NUM_OUT-1:0]     s_out_valid,
    input  logic [NUM_OUT-1:0]     s_out_rdy,
    output logic [NUM_OUT*W-1:0]   s_out_data,
    input  logic [31:0]            bus_addr,
    input  logic                   bus_wr,
    input  logic                   bus_rd,
    input  logic [31:0]            bus_din,
    output logic [31:0]            bus_dout,
    output logic                   bus_dout_valid
);
    localparam int DW = $clog2(NUM_OUT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [31:0]          off;
    logic [7:0]           divisor;
    logic                 mode;
    logic                 err;
    logic                 run;
    logic                 clr_cnt;
    logic                 clr_err;
    logic                 xfer;
    logic                 bus_din_unused;

    logic                 s0_valid;
    logic [W-1:0]         s0_data;
    logic [7:0]           s0_div;
    logic                 s0_mode;
    logic [7:0]           key8;
    logic [7:0]           residue;
    logic [DW-1:0]        dest_next;

    logic                 s1_valid;
    logic [W-1:0]         s1_data;
    logic [DW-1:0]        s1_dest;
    logic                 s1_adv;
    logic                 push_any;

    logic [NUM_OUT-1:0]   full_vec;
    logic [NUM_OUT-1:0]   empty_vec;
    logic [NUM_OUT*32-1:0] count_flat;
    logic [31:0]          rdata;

    assign off            = bus_addr - BASE_ADDR;
    assign clr_cnt        = bus_wr && (off == 32'h8) && bus_din[0];
    assign clr_err        = bus_wr && (off == 32'h8) && bus_din[1];
    assign bus_din_unused = ^bus_din[31:8];

    // Input is held off until the first edge after reset, then only blocked by a stalled S0.
    assign s_in_rdy = run && !(s0_valid && !s1_adv);
    assign xfer     = s_in_valid && s_in_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run     <= 1'b0;
            divisor <= 8'd2;
            mode    <= 1'b0;
            err     <= 1'b0;
        end else begin
            run <= 1'b1;
            if (bus_wr && off == 32'h0) divisor <= bus_din[7:0];
            if (bus_wr && off == 32'h4) mode <= bus_din[0];
            if (clr_err) err <= 1'b0;
            if (xfer && divisor == 8'd0) err <= 1'b1;
        end
    end

    // S0 captures the routing configuration together with the word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_valid <= 1'b0;
            s0_data  <= '0;
            s0_div   <= 8'd0;
            s0_mode  <= 1'b0;
        end else if (xfer) begin
            s0_valid <= 1'b1;
            s0_data  <= s_in_data;
            s0_div   <= divisor;
            s0_mode  <= mode;
        end else if (s1_adv) begin
            s0_valid <= 1'b0;
        end
    end

    always_comb begin
        key8      = 8'(s0_data[KEY_BITS-1:0]);
        residue   = 8'd0;
        dest_next = '0;
        if (s0_div != 8'd0) begin
            residue = key8 % s0_div;
            if (!s0_mode)
                dest_next = (residue == 8'd0) ? DW'(1) : '0;
            else if (residue < 8'(NUM_OUT))
                dest_next = residue[DW-1:0];
            else
                dest_next = DW'(NUM_OUT - 1);
        end
    end

    assign s1_adv   = !s1_valid || !full_vec[s1_dest];
    assign push_any = s1_valid && !full_vec[s1_dest];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_dest  <= '0;
        end else if (s1_adv) begin
            s1_valid <= s0_valid;
            s1_data  <= s0_data;
            s1_dest  <= dest_next;
        end
    end

    // Credit covers the FIFO plus its output register, so a full credit means no free slot.
    for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
        logic [W-1:0]  mem [FIFO_DEPTH];
        logic [AW-1:0] wptr;
        logic [AW-1:0] rptr;
        logic [CW-1:0] cnt;
        logic [CW-1:0] credit;
        logic          ovalid;
        logic [W-1:0]  odata;
        logic [31:0]   count;
        logic          push;
        logic          pop;
        logic          load;

        assign push = push_any && (s1_dest == DW'(k));
        assign pop  = ovalid && s_out_rdy[k];
        assign load = (cnt != '0) && (!ovalid || s_out_rdy[k]);

        always_ff @(posedge clk) begin
            if (push) mem[wptr] <= s1_data;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wptr   <= '0;
                rptr   <= '0;
                cnt    <= '0;
                credit <= '0;
                ovalid <= 1'b0;
                odata  <= '0;
                count  <= 32'd0;
            end else begin
                if (push) wptr <= wptr + AW'(1);
                if (load) rptr <= rptr + AW'(1);
                cnt    <= cnt + CW'(push) - CW'(load);
                credit <= credit + CW'(push) - CW'(pop);
                if (load) begin
                    ovalid <= 1'b1;
                    odata  <= mem[rptr];
                end else if (pop) begin
                    ovalid <= 1'b0;
                end
                if (clr_cnt)
                    count <= push ? 32'd1 : 32'd0;
                else if (push)
                    count <= count + 32'd1;
            end
        end

        assign full_vec[k]             = (credit >= CW'(FIFO_DEPTH));
        assign empty_vec[k]            = (credit == '0);
        assign s_out_valid[k]          = ovalid;
        assign s_out_data[k*W +: W]    = odata;
        assign count_flat[k*32 +: 32]  = count;
    end

    always_comb begin
        rdata = 32'd0;
        case (off)
            32'h0:   rdata = {24'd0, divisor};
            32'h4:   rdata = {31'd0, mode};
            32'hC:   rdata = 32'({empty_vec, 7'd0, err});
            default: rdata = 32'd0;
        endcase
        for (int k = 0; k < NUM_OUT; k++)
            if (off == 32'(16 + 4 * k)) rdata = count_flat[k*32 +: 32];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_dout       <= 32'd0;
            bus_dout_valid <= 1'b0;
        end else begin
            bus_dout_valid <= bus_rd;
            bus_dout       <= bus_rd ? rdata : 32'd0;
        end
    end

endmodule
